branch_redirect_unit: RTL and testbench

BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

---
 rtl/branch_pkg.sv | 40 ++++
 rtl/bru_target_calc.sv | 36 +++
 rtl/branch_redirect_unit.sv | 117 +++++++++++
 tb/tb_branch_redirect_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch redirect unit: EX op codes, FSM states,
// the EX resolve payload and the sequential PC increment.
package branch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 6;

  localparam logic [SEL_W-1:0] ALU_JAL  = 6'b000011;
  localparam logic [SEL_W-1:0] ALU_JALR = 6'b000100;
  localparam logic [SEL_W-1:0] ALU_BEQ  = 6'b000101;
  localparam logic [SEL_W-1:0] ALU_BNE  = 6'b000110;
  localparam logic [SEL_W-1:0] ALU_BLT  = 6'b000111;
  localparam logic [SEL_W-1:0] ALU_BGE  = 6'b001000;
  localparam logic [SEL_W-1:0] ALU_BLTU = 6'b001001;
  localparam logic [SEL_W-1:0] ALU_BGEU = 6'b001010;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } bru_state_e;

  // Everything the EX stage hands over to resolve one control-flow instruction
  typedef struct packed {
    logic [SEL_W-1:0] alu_select;
    logic             branch_taken;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
  } ex_resolve_t;

  // True for the six conditional branch encodings (BEQ..BGEU)
  function automatic logic is_cond_branch(input logic [SEL_W-1:0] sel);
    return (sel >= ALU_BEQ) && (sel <= ALU_BGEU);
  endfunction

endpackage

// File: rtl/bru_target_calc.sv
// Combinational resolution of one EX control-flow instruction: actual target,
// actual next PC, link address and mispredict flag.
module bru_target_calc
  import branch_pkg::*;
(
  input  ex_resolve_t      ex,
  output logic             is_cf_c,
  output logic             mispredict_c,
  output logic [XLEN-1:0]  next_pc_c,
  output logic [XLEN-1:0]  link_pc_c
);

  logic            is_jal;
  logic            is_jalr;
  logic            is_br;
  logic            taken;
  logic [XLEN-1:0] target;

  // Decode the op, compute target/next PC and compare against the prediction
  always_comb begin
    is_jal       = (ex.alu_select == ALU_JAL);
    is_jalr      = (ex.alu_select == ALU_JALR);
    is_br        = is_cond_branch(ex.alu_select);
    is_cf_c      = is_jal | is_jalr | is_br;
    taken        = is_jal | is_jalr | (is_br & ex.branch_taken);
    link_pc_c    = ex.pc + PC_INC;
    target       = ex.pc + ex.imm;
    if (is_jalr) begin
      target = (ex.rs1 + ex.imm) & ~XLEN'(1);
    end
    next_pc_c    = taken ? target : link_pc_c;
    mispredict_c = (taken != ex.pred_taken) |
                   (taken & ex.pred_taken & (target != ex.pred_target));
  end

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves EX control flow against the fetch prediction
// and, on a mispredict, holds a redirect to fetch until it is accepted while
// flushing the younger stages and stalling EX.
// Optional feature macro: BRU_PERF_CNT_EN adds saturating resolve/mispredict
// counters (perf_branches, perf_mispredicts).
module branch_redirect_unit
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [5:0]  ex_alu_select,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        redirect_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        ex_stall,
  output logic [31:0] link_pc
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  bru_state_e      state;
  ex_resolve_t     ex_bundle;
  logic            is_cf_c;
  logic            mispredict_c;
  logic [XLEN-1:0] next_pc_c;
  logic            resolve_c;

  // Pack EX inputs into the resolve payload
  always_comb begin
    ex_bundle              = '0;
    ex_bundle.alu_select   = ex_alu_select;
    ex_bundle.branch_taken = ex_branch_taken;
    ex_bundle.pc           = ex_pc;
    ex_bundle.imm          = ex_imm;
    ex_bundle.rs1          = ex_rs1;
    ex_bundle.pred_taken   = ex_pred_taken;
    ex_bundle.pred_target  = ex_pred_target;
  end

  bru_target_calc u_target_calc (
    .ex           (ex_bundle),
    .is_cf_c      (is_cf_c),
    .mispredict_c (mispredict_c),
    .next_pc_c    (next_pc_c),
    .link_pc_c    (link_pc)
  );

  // A resolve only happens while EX is not frozen by a pending redirect
  assign resolve_c = ex_valid & ~ex_stall & is_cf_c;

  // Redirect FSM with registered handshake, flush and stall outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC;
      flush          <= 1'b0;
      ex_stall       <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (resolve_c && mispredict_c) begin
            state          <= ST_PEND;
            redirect_valid <= 1'b1;
            redirect_pc    <= next_pc_c;
            flush          <= 1'b1;
            ex_stall       <= 1'b1;
          end
        end
        ST_PEND: begin
          if (redirect_ready) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            ex_stall       <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          redirect_valid <= 1'b0;
          ex_stall       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  // Saturating counters of resolve events and mispredicts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve_c && (perf_branches != 32'hFFFF_FFFF)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (resolve_c && mispredict_c && (perf_mispredicts != 32'hFFFF_FFFF)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit; redirect targets are queued
// when a mispredicting instruction is driven and compared when fetch sees them.
`timescale 1ns/1ps
module tb_branch_redirect_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hDEAD_BEE0;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JALR = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b000101;
  localparam logic [5:0] OP_BNE  = 6'b000110;
  localparam logic [5:0] OP_BLT  = 6'b000111;
  localparam logic [5:0] OP_BGE  = 6'b001000;
  localparam logic [5:0] OP_BLTU = 6'b001001;
  localparam logic [5:0] OP_BGEU = 6'b001010;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic [5:0]  ex_alu_select;
  logic        ex_branch_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        ex_stall;
  logic [31:0] link_pc;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  bit          ok;

  branch_redirect_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ex_valid        (ex_valid),
    .ex_alu_select   (ex_alu_select),
    .ex_branch_taken (ex_branch_taken),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_rs1          (ex_rs1),
    .ex_pred_taken   (ex_pred_taken),
    .ex_pred_target  (ex_pred_target),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .ex_stall        (ex_stall),
    .link_pc         (link_pc)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ex_idle();
    ex_valid        = 1'b0;
    ex_alu_select   = OP_NONE;
    ex_branch_taken = 1'b0;
    ex_pc           = '0;
    ex_imm          = '0;
    ex_rs1          = '0;
    ex_pred_taken   = 1'b0;
    ex_pred_target  = '0;
  endtask

  task automatic drive(input logic [5:0] sel, input logic tk, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1,
                       input logic ptk, input logic [31:0] ptgt);
    ex_valid        = 1'b1;
    ex_alu_select   = sel;
    ex_branch_taken = tk;
    ex_pc           = pc;
    ex_imm          = imm;
    ex_rs1          = rs1;
    ex_pred_taken   = ptk;
    ex_pred_target  = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until redirect_valid reaches lvl; ok=0 on timeout
  task automatic wait_valid(input logic lvl, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (redirect_valid === lvl) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (redirect_valid === lvl) found = 1'b1;
  endtask

  task automatic pop_exp(output logic [31:0] v);
    if (exp_q.size() == 0) v = 32'hxxxx_xxxx;
    else v = exp_q.pop_front();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    redirect_ready = 1'b0;
    ex_idle();
    #12;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL rst_flush got %0b exp 0", flush); else n_pass++;
    n_checks++; if (ex_stall !== 1'b0) $display("FAIL rst_stall got %0b exp 0", ex_stall); else n_pass++;
    n_checks++; if (redirect_pc !== TB_RESET_PC) $display("FAIL rst_pc got %h exp %h", redirect_pc, TB_RESET_PC); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL post_rst_valid got %0b exp 0", redirect_valid); else n_pass++;
  endtask

  task automatic test_beq_mispredict();
    redirect_ready = 1'b0;
    drive(OP_BEQ, 1'b1, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h120);
    #1;
    n_checks++; if (link_pc !== 32'h104) $display("FAIL beq_link got %h exp 00000104", link_pc); else n_pass++;
    step();
    ex_idle();
    n_checks++; if (flush !== 1'b1) $display("FAIL beq_flush got %0b exp 1", flush); else n_pass++;
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL beq_valid got %0b exp 1", redirect_valid); else n_pass++;
    n_checks++; if (ex_stall !== 1'b1) $display("FAIL beq_stall got %0b exp 1", ex_stall); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL beq_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL beq_done_valid got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (ex_stall !== 1'b0) $display("FAIL beq_done_stall got %0b exp 0", ex_stall); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL beq_done_flush got %0b exp 0", flush); else n_pass++;
  endtask

  task automatic test_bne_not_taken();
    redirect_ready = 1'b1;
    drive(OP_BNE, 1'b0, 32'h200, 32'h40, 32'h0, 1'b1, 32'h240);
    exp_q.push_back(32'h204);
    step();
    ex_idle();
    wait_valid(1'b1, 4, ok);
    n_checks++; if (!ok) $display("FAIL bne_wait got timeout exp redirect"); else n_pass++;
    n_checks++; if (flush !== 1'b1) $display("FAIL bne_flush got %0b exp 1", flush); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL bne_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL bne_accept got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL bne_flush_once got %0b exp 0", flush); else n_pass++;
    redirect_ready = 1'b0;
  endtask

  task automatic test_jalr_correct();
    drive(OP_JALR, 1'b0, 32'h300, 32'h4, 32'h1003, 1'b1, 32'h1006);
    #1;
    n_checks++; if (link_pc !== 32'h304) $display("FAIL jalr_link got %h exp 00000304", link_pc); else n_pass++;
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL jalr_valid got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL jalr_flush got %0b exp 0", flush); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h204) $display("FAIL jalr_pc_hold got %h exp 00000204", redirect_pc); else n_pass++;
  endtask

  task automatic test_stall_hold();
    redirect_ready = 1'b0;
    drive(OP_JAL, 1'b0, 32'h400, 32'hFFFF_FF00, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h300);
    step();
    // A mispredicting branch sits in EX while pending; it must be ignored
    drive(OP_BEQ, 1'b1, 32'h700, 32'h10, 32'h0, 1'b0, 32'h0);
    pop_exp(exp_pc);
    for (int c = 1; c <= 4; c++) begin
      n_checks++; if (redirect_valid !== 1'b1) $display("FAIL hold_valid_c%0d got %0b exp 1", c, redirect_valid); else n_pass++;
      n_checks++; if (ex_stall !== 1'b1) $display("FAIL hold_stall_c%0d got %0b exp 1", c, ex_stall); else n_pass++;
      n_checks++; if (flush !== (c == 1)) $display("FAIL hold_flush_c%0d got %0b exp %0b", c, flush, (c == 1)); else n_pass++;
      n_checks++; if (redirect_pc !== exp_pc) $display("FAIL hold_pc_c%0d got %h exp %h", c, redirect_pc, exp_pc); else n_pass++;
      if (c == 4) redirect_ready = 1'b1;
      step();
    end
    ex_idle();
    redirect_ready = 1'b0;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL hold_release got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (ex_stall !== 1'b0) $display("FAIL hold_release_stall got %0b exp 0", ex_stall); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL hold_ignored got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h300) $display("FAIL hold_ignored_pc got %h exp 00000300", redirect_pc); else n_pass++;
  endtask

  task automatic test_target_mismatch();
    redirect_ready = 1'b1;
    drive(OP_BLT, 1'b1, 32'h800, 32'h80, 32'h0, 1'b1, 32'h900);
    exp_q.push_back(32'h880);
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL tgt_valid got %0b exp 1", redirect_valid); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL tgt_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    step();
    // Correct taken prediction, non control-flow op and invalid slot: no redirect
    drive(OP_BGE, 1'b1, 32'h800, 32'h80, 32'h0, 1'b1, 32'h880);
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL tgt_correct got %0b exp 0", redirect_valid); else n_pass++;
    drive(OP_NONE, 1'b1, 32'h900, 32'h40, 32'h0, 1'b1, 32'h123);
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL noncf_valid got %0b exp 0", redirect_valid); else n_pass++;
    drive(OP_BEQ, 1'b1, 32'h900, 32'h40, 32'h0, 1'b0, 32'h0);
    ex_valid = 1'b0;
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL invalid_slot got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== 32'h880) $display("FAIL tgt_pc_hold got %h exp 00000880", redirect_pc); else n_pass++;
    redirect_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    redirect_ready = 1'b1;
    drive(OP_BNE, 1'b1, 32'h1000, 32'h100, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h1100);
    step();
    drive(OP_JAL, 1'b0, 32'h2000, 32'h8, 32'h0, 1'b1, 32'h2010);
    exp_q.push_back(32'h2008);
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL b2b_a_valid got %0b exp 1", redirect_valid); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL b2b_a_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    step();
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL b2b_gap got %0b exp 0", redirect_valid); else n_pass++;
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL b2b_b_valid got %0b exp 1", redirect_valid); else n_pass++;
    n_checks++; if (flush !== 1'b1) $display("FAIL b2b_b_flush got %0b exp 1", flush); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL b2b_b_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    step();
    redirect_ready = 1'b0;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL b2b_done got %0b exp 0", redirect_valid); else n_pass++;
  endtask

  task automatic test_reset_in_pend();
    redirect_ready = 1'b0;
    drive(OP_BLTU, 1'b1, 32'h600, 32'h40, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h640);
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL rp_valid got %0b exp 1", redirect_valid); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL rp_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++; if (redirect_valid !== 1'b0) $display("FAIL rp_async_valid got %0b exp 0", redirect_valid); else n_pass++;
    n_checks++; if (redirect_pc !== TB_RESET_PC) $display("FAIL rp_async_pc got %h exp %h", redirect_pc, TB_RESET_PC); else n_pass++;
    n_checks++; if (ex_stall !== 1'b0) $display("FAIL rp_async_stall got %0b exp 0", ex_stall); else n_pass++;
    n_checks++; if (flush !== 1'b0) $display("FAIL rp_async_flush got %0b exp 0", flush); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    // Resolve on the first edge after release, with a wrapping target
    drive(OP_BGEU, 1'b1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h0000_0010);
    step();
    ex_idle();
    n_checks++; if (redirect_valid !== 1'b1) $display("FAIL rp_first_valid got %0b exp 1", redirect_valid); else n_pass++;
    pop_exp(exp_pc);
    n_checks++; if (redirect_pc !== exp_pc) $display("FAIL rp_first_pc got %h exp %h", redirect_pc, exp_pc); else n_pass++;
    redirect_ready = 1'b1;
    wait_valid(1'b0, 4, ok);
    n_checks++; if (!ok) $display("FAIL rp_release got timeout exp valid low"); else n_pass++;
    redirect_ready = 1'b0;
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (perf_branches !== 32'd0) $display("FAIL perf_rst_br got %0d exp 0", perf_branches); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    redirect_ready = 1'b1;
    drive(OP_BEQ, 1'b0, 32'h100, 32'h8, 32'h0, 1'b0, 32'h0);
    step();
    drive(OP_BNE, 1'b1, 32'h100, 32'h8, 32'h0, 1'b0, 32'h0);
    step();
    ex_idle();
    step();
    drive(OP_NONE, 1'b1, 32'h100, 32'h8, 32'h0, 1'b1, 32'h0);
    step();
    drive(OP_JAL, 1'b0, 32'h500, 32'h10, 32'h0, 1'b1, 32'h510);
    step();
    drive(OP_JALR, 1'b0, 32'h500, 32'h0, 32'h2000, 1'b1, 32'h3000);
    step();
    ex_idle();
    step();
    drive(OP_BGE, 1'b1, 32'h600, 32'h20, 32'h0, 1'b1, 32'h620);
    step();
    ex_idle();
    redirect_ready = 1'b0;
    n_checks++; if (perf_branches !== 32'd5) $display("FAIL perf_branches got %0d exp 5", perf_branches); else n_pass++;
    n_checks++; if (perf_mispredicts !== 32'd2) $display("FAIL perf_mispredicts got %0d exp 2", perf_mispredicts); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bne_not_taken();
    test_jalr_correct();
    test_stall_hold();
    test_target_mismatch();
    test_back_to_back();
    test_reset_in_pend();
`ifdef BRU_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
